// File: rtl/serial_mag_comp_ctrl.sv
// Bit-serial magnitude comparator sequencer: scans two latched operands MSB first through a
// 1-bit compare cell and stops at the first differing bit.
module serial_mag_comp_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             Eq,
   output logic             Le,
   output logic             Gt
);

   localparam int IDXW = $clog2(WIDTH);
   localparam logic [IDXW-1:0] IDX_MSB = IDXW'(WIDTH - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_ra;
   logic [WIDTH-1:0] r_rb;
   logic [IDXW-1:0]  r_idx;
   logic             r_done;
   logic             r_eq;
   logic             r_le;
   logic             r_gt;

   logic w_a;
   logic w_b;
   logic w_cell_eq;

   // Shared 1-bit compare cell fed by the current bit of each latched operand.
   assign w_a       = r_ra[r_idx];
   assign w_b       = r_rb[r_idx];
   assign w_cell_eq = ~(w_a ^ w_b);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ra    <= '0;
         r_rb    <= '0;
         r_idx   <= IDX_MSB;
         r_done  <= 1'b0;
         r_eq    <= 1'b0;
         r_le    <= 1'b0;
         r_gt    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_ra    <= A;
                  r_rb    <= B;
                  r_idx   <= IDX_MSB;
                  r_eq    <= 1'b0;
                  r_le    <= 1'b0;
                  r_gt    <= 1'b0;
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (!w_cell_eq) begin
                  // First differing bit decides: A has the 1 means A > B.
                  r_gt    <= w_a;
                  r_le    <= ~w_a;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (r_idx == '0) begin
                  r_eq    <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_idx <= r_idx - IDXW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (r_state == ST_SCAN);
   assign done = r_done;
   assign Eq   = r_eq;
   assign Le   = r_le;
   assign Gt   = r_gt;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Self-checking bench for serial_mag_comp_ctrl: vector table, corner sequences and random
// operands checked against an arithmetic reference model.
module tb_serial_mag_comp_ctrl;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic             Eq;
   logic             Le;
   logic             Gt;

   int n_checks;
   int n_errors;

   serial_mag_comp_ctrl #(
      .WIDTH(WIDTH)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .A    (A),
      .B    (B),
      .busy (busy),
      .done (done),
      .Eq   (Eq),
      .Le   (Le),
      .Gt   (Gt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       gt;
      logic       le;
      logic       eq;
      int         lat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference latency: WIDTH - (index of highest differing bit), or WIDTH when equal.
   function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b);
      int x;
      x = int'(a ^ b);
      if (x == 0) return WIDTH;
      return WIDTH - ($clog2(x + 1) - 1);
   endfunction

   task automatic chk_res(input string name, input logic gt, input logic le, input logic eq);
      chk({name, ".Gt"}, int'(Gt), int'(gt));
      chk({name, ".Le"}, int'(Le), int'(le));
      chk({name, ".Eq"}, int'(Eq), int'(eq));
   endtask

   // Wait for done with a bound; returns the number of edges taken.
   task automatic wait_done(output int cnt);
      cnt = 0;
      while (cnt < 20) begin
         step();
         cnt++;
         if (done) break;
      end
   endtask

   // Accept one operation, then wait for done; ends in the done cycle.
   task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b);
      int cnt;
      A = a;
      B = b;
      start = 1'b1;
      step();
      start = 1'b0;
      chk({name, ".busy_acc"}, int'(busy), 1);
      chk({name, ".clear"}, int'({Gt, Le, Eq, done}), 0);
      wait_done(cnt);
      chk({name, ".lat"}, cnt, ref_lat(a, b));
      chk_res(name, a > b, a < b, a == b);
      chk({name, ".busy_done"}, int'(busy), 0);
   endtask

   initial begin
      int cnt;
      logic [7:0] ra;
      logic [7:0] rb;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      start = 1'b0;
      A = '0;
      B = '0;

      vecs[0] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1};
      vecs[1] = '{8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 8};
      vecs[2] = '{8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 8};
      vecs[3] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1};
      vecs[4] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 8};
      vecs[5] = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8};
      vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8};
      vecs[7] = '{8'h3C, 8'h2C, 1'b1, 1'b0, 1'b0, 4};

      // Reset state, then idle with start low changes nothing.
      step();
      step();
      chk("rst.outs", int'({busy, done, Gt, Le, Eq}), 0);
      rst = 1'b0;
      A = 8'hA5;
      B = 8'h3C;
      for (int i = 0; i < 3; i++) step();
      chk("idle.outs", int'({busy, done, Gt, Le, Eq}), 0);

      // Table-driven vectors.
      for (int i = 0; i < 8; i++) begin
         A = vecs[i].a;
         B = vecs[i].b;
         start = 1'b1;
         step();
         start = 1'b0;
         chk($sformatf("vec%0d.busy", i), int'(busy), 1);
         chk($sformatf("vec%0d.clear", i), int'({Gt, Le, Eq}), 0);
         wait_done(cnt);
         chk($sformatf("vec%0d.lat", i), cnt, vecs[i].lat);
         chk_res($sformatf("vec%0d", i), vecs[i].gt, vecs[i].le, vecs[i].eq);
         step();
         chk($sformatf("vec%0d.done_pulse", i), int'(done), 0);
      end

      // Results held after completion.
      run_op("hold", 8'h5A, 8'h5A);
      for (int i = 0; i < 5; i++) step();
      chk_res("hold5", 1'b0, 1'b0, 1'b1);
      chk("hold5.done", int'({busy, done}), 0);

      // Operands and start changing mid-scan have no effect.
      A = 8'h12;
      B = 8'h13;
      start = 1'b1;
      step();
      start = 1'b0;
      cnt = 1;
      step();
      step();
      A = 8'hFF;
      B = 8'h00;
      start = 1'b1;
      step();
      start = 1'b0;
      cnt = 3;
      while (!done && cnt < 20) begin
         step();
         cnt++;
      end
      chk("midscan.lat", cnt, 8);
      chk_res("midscan", 1'b0, 1'b1, 1'b0);
      step();

      // Back-to-back: start held through the done cycle re-accepts immediately.
      A = 8'h40;
      B = 8'h00;
      start = 1'b1;
      step();
      step();
      chk("b2b.first_done", int'(done), 0);
      step();
      chk("b2b.gt_done", int'(done), 1);
      chk_res("b2b.first", 1'b1, 1'b0, 1'b0);
      A = 8'h00;
      B = 8'h01;
      step();
      start = 1'b0;
      chk("b2b.reaccept", int'({busy, done, Gt, Le, Eq}), 5'b10000);
      wait_done(cnt);
      chk("b2b.second_lat", cnt, 8);
      chk_res("b2b.second", 1'b0, 1'b1, 1'b0);
      step();

      // Reset mid-scan aborts with no done pulse.
      A = 8'hFF;
      B = 8'hFF;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("abort.busy_pre", int'(busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort.outs", int'({busy, done, Gt, Le, Eq}), 0);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         cnt += int'(done);
      end
      chk("abort.no_done", cnt, 0);
      run_op("abort.after", 8'hFF, 8'hFF);
      step();

      // Random operands, some close pairs to reach deep bit positions.
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         case ($urandom_range(0, 2))
            0: rb = 8'($urandom);
            1: rb = ra ^ (8'h01 << $urandom_range(0, 7));
            default: rb = ra;
         endcase
         run_op($sformatf("rnd%0d", i), ra, rb);
         if ($urandom_range(0, 1) == 1) step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
